// File: rtl/n_bit_serializer.sv
// Parallel-in, serial-out transmitter: takes an n-bit word over valid/ready
// and shifts it out one bit per enabled clock, then pulses done for one cycle.
//
// Ports:
//   in_clk            rising-edge clock
//   in_nres           asynchronous active-low reset
//   in_data[n-1:0]    parallel word to transmit
//   in_valid          in_data valid this cycle
//   in_enable         shift strobe; serial bit advances only when 1
//   out_ready         block can accept a word this cycle
//   out_serial        current serial bit
//   out_serial_valid  out_serial carries a data bit
//   out_busy          transmission in progress
//   out_done          one-cycle pulse after the last bit is shifted
module n_bit_serializer #(
  parameter int n         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         in_clk,
  input  logic         in_nres,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_enable,
  output logic         out_ready,
  output logic         out_serial,
  output logic         out_serial_valid,
  output logic         out_busy,
  output logic         out_done
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [n-1:0]    sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge in_clk or negedge in_nres) begin
    if (!in_nres) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs depend only on registered state, so there is no
  // combinational path from any input to any output.
  always_comb begin
    state_d          = state_q;
    sh_d             = sh_q;
    cnt_d            = cnt_q;
    out_ready        = 1'b0;
    out_serial       = 1'b0;
    out_serial_valid = 1'b0;
    out_busy         = 1'b0;
    out_done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        out_ready = 1'b1;
        if (in_valid) begin
          sh_d    = in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        out_busy         = 1'b1;
        out_serial_valid = 1'b1;
        out_serial       = LSB_FIRST ? sh_q[0] : sh_q[n-1];
        if (in_enable) begin
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            // Move the next bit toward the output end, zero-filling.
            sh_d  = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      DONE: begin
        out_done = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_n_bit_serializer.sv
// Scoreboard bench for n_bit_serializer: n=8 LSB-first, n=8 MSB-first and
// n=2 LSB-first instances share one stimulus stream.
module tb_n_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       vld;
  logic       en;

  logic [2:0] rdy, ser, sv, busy, done;

  int nb  [3] = '{8, 8, 2};
  bit lsb [3] = '{1'b1, 1'b0, 1'b1};

  int n_cmp = 0;
  int n_bad = 0;

  n_bit_serializer #(.n(8), .LSB_FIRST(1'b1)) u_l8 (
    .in_clk(clk), .in_nres(rst_n), .in_data(din),
    .in_valid(vld), .in_enable(en),
    .out_ready(rdy[0]), .out_serial(ser[0]),
    .out_serial_valid(sv[0]), .out_busy(busy[0]),
    .out_done(done[0])
  );

  n_bit_serializer #(.n(8), .LSB_FIRST(1'b0)) u_m8 (
    .in_clk(clk), .in_nres(rst_n), .in_data(din),
    .in_valid(vld), .in_enable(en),
    .out_ready(rdy[1]), .out_serial(ser[1]),
    .out_serial_valid(sv[1]), .out_busy(busy[1]),
    .out_done(done[1])
  );

  n_bit_serializer #(.n(2), .LSB_FIRST(1'b1)) u_l2 (
    .in_clk(clk), .in_nres(rst_n), .in_data(din[1:0]),
    .in_valid(vld), .in_enable(en),
    .out_ready(rdy[2]), .out_serial(ser[2]),
    .out_serial_valid(sv[2]), .out_busy(busy[2]),
    .out_done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, int k, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] got %b expected %b at %0t", nm, k, a, e, $time);
    end
  endfunction

  // Reference model: bits still to send, a pending done pulse, and the
  // expected serial sequence in transmit order.
  int rem [3];
  bit dn  [3];
  bit expq [3][$];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        rem[k] <= 0;
        dn[k]  <= 1'b0;
        expq[k].delete();
      end else if (dn[k]) begin
        dn[k] <= 1'b0;
      end else if (rem[k] == 0) begin
        if (vld) begin
          for (int i = 0; i < nb[k]; i++)
            expq[k].push_back(din[lsb[k] ? i : nb[k] - 1 - i]);
          rem[k] <= nb[k];
        end
      end else if (en) begin
        rem[k] <= rem[k] - 1;
        if (rem[k] == 1) dn[k] <= 1'b1;
      end
    end
  end

  // Monitor: compares flags every cycle, pops a bit whenever the
  // consumer would sample one.
  logic [2:0] psv, pser;
  logic       pen;
  int         cyc = 0;
  int         firsts[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      psv = '0;
      pen = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        chk("ready", k, rdy[k], rem[k] == 0 && !dn[k]);
        chk("busy", k, busy[k], rem[k] != 0);
        chk("svalid", k, sv[k], rem[k] != 0);
        chk("done", k, done[k], dn[k]);
        if (!sv[k]) chk("idle_serial", k, ser[k], 1'b0);
        if (sv[k] && psv[k] && !pen) chk("hold", k, ser[k], pser[k]);
        if (sv[k] && en) begin
          if (expq[k].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL underflow[%0d] got bit %b expected none", k, ser[k]);
          end else begin
            chk("bit", k, ser[k], expq[k].pop_front());
          end
        end
      end
      if (sv[0] && !psv[0]) firsts.push_back(cyc);
      psv  = sv;
      pser = ser;
      pen  = en;
    end
  end

  task automatic tick(int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] w, int idle);
    vld = 1'b1;
    din = w;
    en  = 1'b1;
    tick(1);
    vld = 1'b0;
    tick(idle);
  endtask

  task automatic chk_reset_outs(string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_ready"}, k, rdy[k], 1'b1);
      chk({nm, "_serial"}, k, ser[k], 1'b0);
      chk({nm, "_svalid"}, k, sv[k], 1'b0);
      chk({nm, "_busy"}, k, busy[k], 1'b0);
      chk({nm, "_done"}, k, done[k], 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    vld   = 1'b0;
    din   = '0;
    en    = 1'b0;
    #3;
    chk_reset_outs("rst");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    send(8'hA5, 12);
    send(8'h01, 12);
    send(8'h02, 12);

    // Stall: enable pulses once every three cycles.
    vld = 1'b1;
    din = 8'hC3;
    en  = 1'b1;
    tick(1);
    vld = 1'b0;
    for (int i = 0; i < 30; i++) begin
      en = (i % 3 == 0);
      tick(1);
    end
    en = 1'b1;
    tick(5);

    // Handshake: valid held through SHIFT and DONE.
    firsts.delete();
    vld = 1'b1;
    din = 8'hFF;
    en  = 1'b1;
    tick(1);
    din = 8'h00;
    tick(20);
    vld = 1'b0;
    tick(15);
    n_cmp++;
    if (firsts.size() < 2) begin
      n_bad++;
      $display("FAIL gap got %0d first-bits expected 2", firsts.size());
    end else if (firsts[1] - firsts[0] != 10) begin
      n_bad++;
      $display("FAIL gap got %0d expected 10", firsts[1] - firsts[0]);
    end

    // Reset in the middle of a word.
    vld = 1'b1;
    din = 8'h5A;
    en  = 1'b1;
    tick(1);
    vld = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk_reset_outs("post");
    send(8'h3C, 12);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      vld = ($urandom_range(0, 3) == 0);
      din = 8'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    vld = 1'b0;
    en  = 1'b1;
    tick(20);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (expq[k].size() != 0) begin
        n_bad++;
        $display("FAIL drain[%0d] got %0d bits left expected 0", k, expq[k].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
